// File: rtl/exp4_interface_hcsr04_pkg.sv
// Shared state encodings, BCD width and the saturating BCD increment used by the
// HC-SR04 ranging front-end and its cm counter.
package exp4_interface_hcsr04_pkg;

    localparam int BCD_W = 12;

    localparam logic [3:0] INICIAL       = 4'h0;
    localparam logic [3:0] PREPARACAO    = 4'h1;
    localparam logic [3:0] ENVIA_TRIGGER = 4'h2;
    localparam logic [3:0] ESPERA_ECHO   = 4'h3;
    localparam logic [3:0] MEDE_ECHO     = 4'h4;
    localparam logic [3:0] ARMAZENA      = 4'h5;
    localparam logic [3:0] FINAL_MEDIDA  = 4'h6;
    localparam logic [3:0] ERRO          = 4'h7;
    localparam logic [3:0] DB_ILEGAL     = 4'hF;

    localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

    // Three-digit BCD +1 that sticks at 999 instead of rolling over.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/exp4_interface_hcsr04_if.sv
// Measurement request/result bundle between the control unit and the ranging front-end.
interface exp4_interface_hcsr04_if;
    import exp4_interface_hcsr04_pkg::*;

    logic             medir;
    logic             pronto;
    logic [BCD_W-1:0] medida;
    logic             timeout;

    modport master (output medir, input pronto, input medida, input timeout);
    modport slave  (input medir, output pronto, output medida, output timeout);
endinterface

// File: rtl/exp4_interface_hcsr04_contador.sv
// Three-digit BCD up counter with synchronous clear, saturating at 999.
module contador_bcd_3digitos
    import exp4_interface_hcsr04_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    output logic [BCD_W-1:0] bcd
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      bcd <= '0;
        else if (zera)  bcd <= '0;
        else if (conta) bcd <= bcd_inc(bcd);
    end

endmodule

// File: rtl/exp4_interface_hcsr04.sv
// HC-SR04 front-end: fires the trigger pulse, times the echo and reports the
// distance in cm as three BCD digits, with a timeout fallback of 999.
module exp4_interface_hcsr04
    import exp4_interface_hcsr04_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  echo,
    output logic                  trigger,
    output logic [3:0]            db_estado,
    exp4_interface_hcsr04_if.slave bus
);

    localparam int TRIG_W = (TRIG_CYCLES    > 1) ? $clog2(TRIG_CYCLES)    : 1;
    localparam int TICK_W = (CYCLES_PER_CM  > 1) ? $clog2(CYCLES_PER_CM)  : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_CM - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CYCLES_PER_CM / 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic              echo_m, echo_s;
    logic [3:0]        state, next;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [BCD_W-1:0]  bcd, medida;
    logic              timeout, to_last, tick_wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    assign to_last   = (to_cnt == TO_LAST);
    assign tick_wrap = (state == MEDE_ECHO) && (tick_cnt == TICK_LAST);

    // Timeout is tested before the echo level so it wins a same-cycle tie.
    always_comb begin
        next = state;
        case (state)
            INICIAL:       if (bus.medir) next = PREPARACAO;
            PREPARACAO:    next = ENVIA_TRIGGER;
            ENVIA_TRIGGER: if (trig_cnt == TRIG_LAST) next = ESPERA_ECHO;
            ESPERA_ECHO:   if (to_last) next = ERRO; else if (echo_s) next = MEDE_ECHO;
            MEDE_ECHO:     if (to_last) next = ERRO; else if (!echo_s) next = ARMAZENA;
            ARMAZENA:      next = FINAL_MEDIDA;
            ERRO:          next = FINAL_MEDIDA;
            FINAL_MEDIDA:  next = INICIAL;
            default:       next = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= INICIAL;
        else       state <= next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_cnt <= '0;
            tick_cnt <= '0;
            to_cnt   <= '0;
        end else if (state == PREPARACAO) begin
            trig_cnt <= '0;
            tick_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (state == ENVIA_TRIGGER && trig_cnt != TRIG_LAST)
                trig_cnt <= trig_cnt + 1'b1;
            if (state == MEDE_ECHO)
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if ((state == ESPERA_ECHO || state == MEDE_ECHO) && !to_last)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    contador_bcd_3digitos u_cm (
        .clock (clock),
        .reset (reset),
        .zera  (state == PREPARACAO),
        .conta (tick_wrap),
        .bcd   (bcd)
    );

    // Residual ticks of half a centimetre or more round the result up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medida  <= '0;
            timeout <= 1'b0;
        end else if (state == ARMAZENA) begin
            medida  <= (tick_cnt >= TICK_HALF) ? bcd_inc(bcd) : bcd;
            timeout <= 1'b0;
        end else if (state == ERRO) begin
            medida  <= BCD_MAX;
            timeout <= 1'b1;
        end
    end

    assign trigger     = (state == ENVIA_TRIGGER);
    assign bus.pronto  = (state == FINAL_MEDIDA);
    assign bus.medida  = medida;
    assign bus.timeout = timeout;
    assign db_estado   = (state <= ERRO) ? state : DB_ILEGAL;

endmodule
